// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: instruction-fetch stage of the 8-bit CPU (PC, boot/interrupt vectoring, IF/ID output registers).
// Revision 1.0 - initial release
module fetch_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall,
  input  logic       flush,
  input  logic       branch_taken,
  input  logic [7:0] branch_target,
  input  logic       intr_req,
  input  logic       intr_ret,
  output logic [7:0] imem_addr,
  input  logic [7:0] imem_data,
  input  logic [7:0] imem_data_p1,
  output logic [7:0] instr,
  output logic [7:0] immediate,
  output logic       imm_valid,
  output logic [7:0] pc_out,
  output logic       valid,
  output logic       intr_ack,
  output logic [7:0] intr_pc,
  output logic       intr_active
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    INT_VEC = 2'd2
  } state_t;

  state_t     state, next_state;
  logic [7:0] pc, next_pc;
  logic       pending;
  logic       intr_req_q;
  logic       accept;
  logic       two_byte;
  logic       load_fetch;
  logic       load_bubble;

  assign two_byte = (imem_data[7:4] == 4'hC);
  assign accept   = (state == RUN) && pending && !intr_active && !stall && !branch_taken;
  assign intr_ack = accept;

  // Priority: branch (ignored in BOOT) > stall > interrupt accept > normal fetch
  always_comb begin
    next_state  = state;
    next_pc     = pc;
    load_fetch  = 1'b0;
    load_bubble = 1'b0;
    imem_addr   = 8'h00;
    case (state)
      BOOT: begin
        if (!stall) begin
          next_pc     = imem_data;
          next_state  = RUN;
          load_bubble = 1'b1;
        end
      end
      RUN: begin
        imem_addr = pc;
        if (branch_taken) begin
          next_pc     = branch_target;
          load_bubble = 1'b1;
        end else if (!stall) begin
          if (accept) begin
            next_state  = INT_VEC;
            load_bubble = 1'b1;
          end else begin
            next_pc     = pc + (two_byte ? 8'd2 : 8'd1);
            load_fetch  = !flush;
            load_bubble = flush;
          end
        end
      end
      INT_VEC: begin
        imem_addr = 8'h01;
        if (branch_taken) begin
          next_pc     = branch_target;
          next_state  = RUN;
          load_bubble = 1'b1;
        end else if (!stall) begin
          next_pc     = imem_data;
          next_state  = RUN;
          load_bubble = 1'b1;
        end
      end
      default: begin
        next_state = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= 8'h00;
    end else begin
      state <= next_state;
      pc    <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr     <= 8'h00;
      immediate <= 8'h00;
      imm_valid <= 1'b0;
      pc_out    <= 8'h00;
      valid     <= 1'b0;
    end else if (load_bubble) begin
      instr     <= 8'h00;
      immediate <= 8'h00;
      imm_valid <= 1'b0;
      pc_out    <= 8'h00;
      valid     <= 1'b0;
    end else if (load_fetch) begin
      instr     <= imem_data;
      immediate <= two_byte ? imem_data_p1 : 8'h00;
      imm_valid <= two_byte;
      pc_out    <= pc;
      valid     <= 1'b1;
    end
  end

  // A new edge arriving in the accept cycle re-arms pending rather than being lost
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      intr_req_q  <= 1'b0;
      pending     <= 1'b0;
      intr_active <= 1'b0;
      intr_pc     <= 8'h00;
    end else begin
      intr_req_q <= intr_req;
      pending    <= (pending && !accept) || (intr_req && !intr_req_q);
      if (accept) begin
        intr_active <= 1'b1;
        intr_pc     <= pc;
      end else if (intr_ret) begin
        intr_active <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the 8-bit pipelined CPU. Owns the program counter and boots from the reset vector at M[0]. Fetches one- or two-byte instructions from the instruction port of the unified memory and presents them, registered, to the IF/ID register. Also takes branch redirects from execute and vectors external interrupts through M[1].

## Interface
- No parameters. Address and data widths are fixed at 8 bits.
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low reset
- stall  in  1  hold PC and output registers
- flush  in  1  replace the next registered output with a bubble
- branch_taken  in  1  redirect from execute
- branch_target  in  8  redirect address
- intr_req  in  1  external interrupt pin, level-sampled
- intr_ret  in  1  one-cycle pulse when RTI retires; clears intr_active
- imem_addr  out  8  instruction address to memory (combinational from state/PC)
- imem_data  in  8  byte at imem_addr (combinational read)
- imem_data_p1  in  8  byte at imem_addr+1 (mod 256)
- instr  out  8  registered opcode byte
- immediate  out  8  registered second byte
- imm_valid  out  1  instr is two-byte
- pc_out  out  8  address of instr
- valid  out  1  instr is a real instruction (0 = bubble)
- intr_ack  out  1  one-cycle pulse when an interrupt is accepted
- intr_pc  out  8  return address captured at accept
- intr_active  out  1  handler in progress

## Operation
- States: BOOT, RUN, INT_VEC.
- BOOT: imem_addr=0x00; PC<=imem_data; go to RUN. Outputs stay bubble.
- RUN: imem_addr=PC.
  - Two-byte instruction when imem_data[7:4]==4'hC. Then PC<=PC+2, else PC<=PC+1. Arithmetic is 8-bit and wraps (0xFF+1=0x00, 0xFF+2=0x01).
  - Output regs load instr=imem_data, immediate=imem_data_p1 (0 if one-byte), imm_valid, pc_out=PC, valid=1.
- Interrupts: a rising edge of intr_req (registered previous value) sets a sticky pending bit.
- Interrupt accept condition: RUN, pending=1, intr_active=0, stall=0, branch_taken=0.
- On accept:
  - intr_ack=1 for that cycle; intr_pc<=PC; pending cleared.
  - intr_active<=1; output loads bubble; next state INT_VEC.
- INT_VEC: imem_addr=0x01; PC<=imem_data; output bubble; go to RUN.
- intr_active clears on intr_ret. Edges arriving while intr_active=1 stay pending and are accepted after intr_ret.
- Per-edge priority, highest first:
  1. reset
  2. branch_taken
  3. stall
  4. interrupt accept
  5. normal fetch
- branch_taken in RUN or INT_VEC:
  - PC<=branch_target; output bubble; state becomes RUN.
  - Overrides stall and flush.
  - Pending interrupt stays pending.
- branch_taken in BOOT is ignored.
- stall (without branch): PC, state and output regs hold. The pending bit can still be set. intr_ack=0.
- flush (without branch or stall): output loads bubble. PC and state advance normally, so the fetched instruction is discarded.
- Bubble definition: instr=0, immediate=0, imm_valid=0, valid=0, pc_out=0.

## Timing
- Reset is asynchronous. While reset=0, all of the following hold:
  - state=BOOT, PC=0, pending=0, intr_active=0, intr_ack=0, intr_pc=0.
  - Outputs are bubble.
  - imem_addr=0.
- Edge 1 after reset release: PC=M[0]. Edge 2: first instruction valid at the output. Fetch-to-output latency is 1 cycle.
- Redirect: branch_taken sampled at edge N gives a bubble after N. The target instruction is valid after N+1.
- Interrupt:
  - Edge at intr_req sampled at edge N sets pending.
  - Accept occurs in cycle N+1 when conditions hold: intr_ack high and bubble output.
  - INT_VEC runs in cycle N+2.
  - The handler's first instruction is valid after edge N+3.
- Throughput is one instruction per cycle with no stall.
- Reset asserted mid-operation clears everything immediately, including pending and intr_active.

## Test plan
- M[0]=0x10, M[0x10]=0x25, release reset → after edge 2: instr=0x25, pc_out=0x10, valid=1. After edge 3: pc_out=0x11.
- M[0x10]=0xC4, M[0x11]=0x7E → instr=0xC4, immediate=0x7E, imm_valid=1. Next pc_out=0x12. Repeat at PC=0xFF with the one-byte instruction 0x25 → next pc_out=0x00.
- stall held 3 cycles mid-stream → outputs and PC are frozen. On release, the sequence resumes with no skipped or duplicated pc_out.
- branch_taken=1 with target 0x40, together with stall=1 and flush=1 → bubble, then pc_out=0x40, valid=1.
- M[1]=0x80; intr_req rises while PC=0x13 → one intr_ack pulse, intr_pc=0x13, two bubbles, then pc_out=0x80, intr_active=1. A second edge before intr_ret is held pending; pulsing intr_ret → it is accepted.
- Assert reset during INT_VEC → immediate bubble outputs, intr_active=0. After release, boot is repeated from M[0].
